// File: rtl/interleaver_ctrl_pkg.sv
// Shared tx definitions: 802.11a RATE codes, per-modulation coded bits per symbol,
// the interleaver sequencer state encoding and the RATE -> NCBPS decode used by interleaver and mapper.
package interleaver_ctrl_pkg;

   localparam logic [3:0] RATE_6M  = 4'b1101;
   localparam logic [3:0] RATE_9M  = 4'b1111;
   localparam logic [3:0] RATE_12M = 4'b0101;
   localparam logic [3:0] RATE_18M = 4'b0111;
   localparam logic [3:0] RATE_24M = 4'b1001;
   localparam logic [3:0] RATE_36M = 4'b1011;
   localparam logic [3:0] RATE_48M = 4'b0001;
   localparam logic [3:0] RATE_54M = 4'b0011;

   localparam int NCBPS_BPSK  = 48;
   localparam int NCBPS_QPSK  = 96;
   localparam int NCBPS_16QAM = 192;
   localparam int NCBPS_64QAM = 288;
   localparam int MAX_NCBPS   = NCBPS_64QAM;
   localparam int NCBPS_W     = $clog2(MAX_NCBPS + 1);

   typedef logic [NCBPS_W-1:0] ncbps_t;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      STREAM,
      DRAIN,
      FIN
   } state_e;

   typedef struct packed {
      logic   legal;
      ncbps_t ncbps;
   } rate_dec_t;

   // Illegal codes report legal=0 with a harmless BPSK length so callers never see X.
   function automatic rate_dec_t decodeRate(input logic [3:0] rate);
      rate_dec_t r;
      r.legal = 1'b1;
      r.ncbps = ncbps_t'(NCBPS_BPSK);
      case (rate)
         RATE_6M,  RATE_9M:  r.ncbps = ncbps_t'(NCBPS_BPSK);
         RATE_12M, RATE_18M: r.ncbps = ncbps_t'(NCBPS_QPSK);
         RATE_24M, RATE_36M: r.ncbps = ncbps_t'(NCBPS_16QAM);
         RATE_48M, RATE_54M: r.ncbps = ncbps_t'(NCBPS_64QAM);
         default:            r.legal = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/interleaver_ctrl_rate_decode.sv
// Combinational RATE field decoder (coded bits per symbol plus legality), shared with the mapper control.
module intlv_rate_decode
   import interleaver_ctrl_pkg::*;
(
   input  logic [3:0]         rate_i,
   output logic [NCBPS_W-1:0] ncbps_o,
   output logic               legal_o
);

   rate_dec_t dec;

   assign dec     = decodeRate(rate_i);
   assign ncbps_o = dec.ncbps;
   assign legal_o = dec.legal;

endmodule

// File: rtl/interleaver_ctrl.sv
// Frame sequencer for the tx interleaver: pulls coded bits, marks symbol starts, flags output valid/last.
// Optional SIGNAL-symbol prefix is enabled with `define INTLV_CTRL_SIGNAL_EN.
module interleaver_ctrl
   import interleaver_ctrl_pkg::*;
#(
   parameter int SYM_W    = 12,
   parameter int PIPE_LAT = 1
)
(
   input  logic               Clock,
   input  logic               Reset,
   input  logic               Start,
   input  logic [3:0]         Rate,
   input  logic [SYM_W-1:0]   NumSym,
   output logic               Busy,
   output logic               Done,
   output logic               RateErr,
   output logic               BitReq,
   output logic               SymStart,
   output logic [NCBPS_W-1:0] NCbps,
   output logic               OutValid,
   output logic               OutLast
);

   localparam logic [SYM_W:0] SYM_ONE = (SYM_W+1)'(1);

   state_e              state_q, state_d;
   ncbps_t              bitCnt_q, bitCnt_d;
   ncbps_t              ncbps_q, ncbps_d;
   logic [SYM_W-1:0]    symCnt_q, symCnt_d;
   logic [SYM_W-1:0]    numSym_q, numSym_d;
   logic                rateErr_q, rateErr_d;
   logic [PIPE_LAT-1:0] validPipe_q, lastPipe_q;

   ncbps_t decNcbps;
   logic   decLegal;
   ncbps_t drainLen;
   logic   accept, symEnd, lastSym, fillLast, drainEnd;
   logic   outPhase, outLastPhase;

`ifdef INTLV_CTRL_SIGNAL_EN
   ncbps_t dataNcbps_q, dataNcbps_d;
`endif

   intlv_rate_decode uRateDecode (
      .rate_i  (Rate),
      .ncbps_o (decNcbps),
      .legal_o (decLegal)
   );

   assign accept   = (state_q == IDLE) && Start && decLegal;
   assign symEnd   = (bitCnt_q == ncbps_q - ncbps_t'(1));
   assign lastSym  = (({1'b0, symCnt_q} + SYM_ONE) == {1'b0, numSym_q});
   assign drainEnd = (bitCnt_q == drainLen + ncbps_t'(PIPE_LAT - 1));

   // With a SIGNAL prefix the output side trails the write side by one 48-bit symbol.
`ifdef INTLV_CTRL_SIGNAL_EN
   assign fillLast = (numSym_q == '0);
   assign drainLen = ncbps_t'(NCBPS_BPSK);
`else
   assign fillLast = lastSym;
   assign drainLen = ncbps_q;
`endif

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
`ifdef INTLV_CTRL_SIGNAL_EN
               state_d = FILL;
`else
               state_d = (NumSym == '0) ? FIN : FILL;
`endif
            end
         end
         FILL:    if (symEnd) state_d = fillLast ? DRAIN : STREAM;
         STREAM:  if (symEnd && lastSym) state_d = DRAIN;
         DRAIN:   if (drainEnd) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Counters restart on every symbol; DRAIN counts through the output tail plus pipeline latency.
   always_comb begin
      bitCnt_d  = '0;
      symCnt_d  = symCnt_q;
      ncbps_d   = ncbps_q;
      numSym_d  = numSym_q;
      rateErr_d = (state_q == IDLE) && Start && !decLegal;
`ifdef INTLV_CTRL_SIGNAL_EN
      dataNcbps_d = dataNcbps_q;
`endif
      case (state_q)
         IDLE: begin
            symCnt_d = '0;
            if (state_d == FILL) begin
               numSym_d = NumSym;
`ifdef INTLV_CTRL_SIGNAL_EN
               ncbps_d     = ncbps_t'(NCBPS_BPSK);
               dataNcbps_d = decNcbps;
`else
               ncbps_d = decNcbps;
`endif
            end
         end
         FILL: begin
            bitCnt_d = symEnd ? '0 : bitCnt_q + ncbps_t'(1);
            if (symEnd) begin
`ifdef INTLV_CTRL_SIGNAL_EN
               ncbps_d = dataNcbps_q;
`else
               symCnt_d = symCnt_q + SYM_W'(1);
`endif
            end
         end
         STREAM: begin
            bitCnt_d = symEnd ? '0 : bitCnt_q + ncbps_t'(1);
            if (symEnd) symCnt_d = symCnt_q + SYM_W'(1);
         end
         DRAIN:   bitCnt_d = bitCnt_q + ncbps_t'(1);
         default: bitCnt_d = '0;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         bitCnt_q    <= '0;
         symCnt_q    <= '0;
         numSym_q    <= '0;
         ncbps_q     <= ncbps_t'(NCBPS_BPSK);
         rateErr_q   <= 1'b0;
         validPipe_q <= '0;
         lastPipe_q  <= '0;
`ifdef INTLV_CTRL_SIGNAL_EN
         dataNcbps_q <= ncbps_t'(NCBPS_BPSK);
`endif
      end else begin
         bitCnt_q      <= bitCnt_d;
         symCnt_q      <= symCnt_d;
         numSym_q      <= numSym_d;
         ncbps_q       <= ncbps_d;
         rateErr_q     <= rateErr_d;
         validPipe_q[0] <= outPhase;
         lastPipe_q[0]  <= outLastPhase;
         for (int i = 1; i < PIPE_LAT; i++) begin
            validPipe_q[i] <= validPipe_q[i-1];
            lastPipe_q[i]  <= lastPipe_q[i-1];
         end
`ifdef INTLV_CTRL_SIGNAL_EN
         dataNcbps_q <= dataNcbps_d;
`endif
      end
   end

   always_comb begin
      Busy         = (state_q != IDLE);
      Done         = (state_q == FIN);
      BitReq       = (state_q == FILL) || (state_q == STREAM);
      SymStart     = BitReq && (bitCnt_q == '0);
      outPhase     = (state_q == STREAM) || ((state_q == DRAIN) && (bitCnt_q < drainLen));
      outLastPhase = (state_q == DRAIN) && (bitCnt_q == drainLen - ncbps_t'(1));
      RateErr      = rateErr_q;
      NCbps        = ncbps_q;
      OutValid     = validPipe_q[PIPE_LAT-1];
      OutLast      = lastPipe_q[PIPE_LAT-1];
   end

endmodule
